// File: rtl/sd_spi_pkg.sv
// Shared types and SPI mode constants for the SD SPI initiator.
package sd_spi_pkg;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, TAIL} spi_state_e;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/sd_spi_master_if.sv
// User-side byte stream plus SPI pins of the SD SPI initiator.
interface sd_spi_master_if #(
  parameter int unsigned DIV_W = 8
);
  logic [DIV_W-1:0] div;
  logic             cs_en;
  logic             tx_valid;
  logic             tx_ready;
  logic [7:0]       tx_data;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             busy;
  logic             sck;
  logic             mosi;
  logic             miso;
  logic             ss;

  modport master (
    input  div, cs_en, tx_valid, tx_data, miso,
    output tx_ready, rx_valid, rx_data, busy, sck, mosi, ss
  );

  modport slave (
    output div, cs_en, tx_valid, tx_data, miso,
    input  tx_ready, rx_valid, rx_data, busy, sck, mosi, ss
  );
endinterface

// File: rtl/spi_half_tick.sv
// Loadable down-counter timing one sck half-period; tick while the count sits at zero.
module spi_half_tick #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             i_clk_sys,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_load_val,
  output logic             o_tick,
  output logic             o_tick_next
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_d;

  always_comb begin
    w_cnt_d = r_cnt;
    if (i_load) begin
      w_cnt_d = i_load_val;
    end else if (r_cnt != '0) begin
      w_cnt_d = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign o_tick      = (r_cnt == '0);
  // Lets the parent register outputs that depend on the next cycle being a tick.
  assign o_tick_next = (w_cnt_d == '0);

endmodule

// File: rtl/sd_spi_master.sv
// Byte-wide SPI mode-0 initiator for the SD link; back-to-back streaming, user-driven ss.
module sd_spi_master
  import sd_spi_pkg::*;
#(
  parameter int unsigned DIV_W     = 8,
  parameter logic        IDLE_MOSI = 1'b1
) (
  input logic             i_clk_sys,
  input logic             i_reset,
  sd_spi_master_if.master io_bus
);

  spi_state_e       r_state, w_state_d;
  logic [2:0]       r_bit, w_bit_d;
  logic [DIV_W-1:0] r_div, w_div_d;
  logic [7:0]       r_tx_shift, w_tx_shift_d;
  logic [7:0]       r_rx_shift, w_rx_shift_d;
  logic             r_pend, w_pend_d;
  logic [7:0]       r_pend_data, w_pend_data_d;
  logic             r_sck, w_sck_d;
  logic             r_mosi, w_mosi_d;
  logic             r_ss, w_ss_d;
  logic             r_tx_ready, w_tx_ready_d;
  logic             r_rx_valid, w_rx_valid_d;
  logic [7:0]       r_rx_data, w_rx_data_d;
  logic             r_busy, w_busy_d;

  logic             w_accept;
  logic             w_load;
  logic [DIV_W-1:0] w_load_val;
  logic             w_tick;
  logic             w_tick_next;

  spi_half_tick #(
    .DIV_W (DIV_W)
  ) u_half_tick (
    .i_clk_sys   (i_clk_sys),
    .i_reset     (i_reset),
    .i_load      (w_load),
    .i_load_val  (w_load_val),
    .o_tick      (w_tick),
    .o_tick_next (w_tick_next)
  );

  assign w_accept = io_bus.tx_valid & r_tx_ready;

  always_comb begin
    w_state_d     = r_state;
    w_bit_d       = r_bit;
    w_div_d       = r_div;
    w_tx_shift_d  = r_tx_shift;
    w_rx_shift_d  = r_rx_shift;
    w_pend_d      = r_pend;
    w_pend_data_d = r_pend_data;
    w_sck_d       = r_sck;
    w_rx_valid_d  = 1'b0;
    w_rx_data_d   = r_rx_data;
    w_load        = 1'b0;
    w_load_val    = r_div;

    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_d    = LOW;
          w_bit_d      = 3'd7;
          w_div_d      = io_bus.div;
          w_load       = 1'b1;
          w_load_val   = io_bus.div;
          w_tx_shift_d = io_bus.tx_data;
        end
      end
      LOW: begin
        // Streaming slot: the next byte waits here until TAIL.
        if (w_accept) begin
          w_pend_d      = 1'b1;
          w_pend_data_d = io_bus.tx_data;
        end
        if (w_tick) begin
          w_state_d = HIGH;
          w_sck_d   = ~SPI_CPOL;
          w_load    = 1'b1;
          if (SPI_CPHA == 1'b0) begin
            w_rx_shift_d = {r_rx_shift[6:0], io_bus.miso};
          end
        end
      end
      HIGH: begin
        if (w_tick) begin
          w_sck_d      = SPI_CPOL;
          w_tx_shift_d = {r_tx_shift[6:0], IDLE_MOSI};
          if (r_bit == 3'd0) begin
            w_state_d = TAIL;
          end else begin
            w_state_d = LOW;
            w_bit_d   = r_bit - 3'd1;
            w_load    = 1'b1;
          end
        end
      end
      TAIL: begin
        w_rx_valid_d = 1'b1;
        w_rx_data_d  = r_rx_shift;
        if (r_pend) begin
          w_pend_d     = 1'b0;
          w_state_d    = LOW;
          w_bit_d      = 3'd7;
          w_div_d      = io_bus.div;
          w_load       = 1'b1;
          w_load_val   = io_bus.div;
          w_tx_shift_d = r_pend_data;
        end else begin
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase

    w_busy_d = (w_state_d != IDLE);
    w_mosi_d = (w_state_d == LOW || w_state_d == HIGH) ? w_tx_shift_d[7] : IDLE_MOSI;
    // ss may assert at once but only releases once no byte is in flight.
    w_ss_d   = io_bus.cs_en ? 1'b0 : (w_busy_d ? r_ss : 1'b1);
  end

  assign w_tx_ready_d = (w_state_d == IDLE) ||
                        (w_state_d == LOW && w_bit_d == 3'd0 && w_tick_next);

  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_bit       <= 3'd7;
      r_div       <= '0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_pend      <= 1'b0;
      r_pend_data <= '0;
      r_sck       <= SPI_CPOL;
      r_mosi      <= IDLE_MOSI;
      r_ss        <= 1'b1;
      r_tx_ready  <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_data   <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_bit       <= w_bit_d;
      r_div       <= w_div_d;
      r_tx_shift  <= w_tx_shift_d;
      r_rx_shift  <= w_rx_shift_d;
      r_pend      <= w_pend_d;
      r_pend_data <= w_pend_data_d;
      r_sck       <= w_sck_d;
      r_mosi      <= w_mosi_d;
      r_ss        <= w_ss_d;
      r_tx_ready  <= w_tx_ready_d;
      r_rx_valid  <= w_rx_valid_d;
      r_rx_data   <= w_rx_data_d;
      r_busy      <= w_busy_d;
    end
  end

  assign io_bus.sck      = r_sck;
  assign io_bus.mosi     = r_mosi;
  assign io_bus.ss       = r_ss;
  assign io_bus.tx_ready = r_tx_ready;
  assign io_bus.rx_valid = r_rx_valid;
  assign io_bus.rx_data  = r_rx_data;
  assign io_bus.busy     = r_busy;

endmodule

// File: tb/tb_sd_spi_master.sv
// Directed bench for sd_spi_master: loopback and SD-responder miso, scoreboarded rx bytes.
module tb_sd_spi_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sd_spi_master_if #(.DIV_W(8)) bus ();

  sd_spi_master #(
    .DIV_W     (8),
    .IDLE_MOSI (1'b1)
  ) dut (
    .i_clk_sys (clk),
    .i_reset   (rst),
    .io_bus    (bus.master)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [7:0] exp_q[$];
  int         rx_cyc_q[$];

  // SD responder: 0xFF until six command bytes have gone by, then 0x01 once.
  logic       mode_resp = 1'b0;
  logic [7:0] rsp_cur   = 8'hFF;
  logic [2:0] rsp_bits  = 3'd0;
  int         rsp_bytes = 0;

  always @(negedge bus.sck) begin
    if (mode_resp) begin
      if (rsp_bits == 3'd7) begin
        rsp_bits  <= 3'd0;
        rsp_bytes <= rsp_bytes + 1;
        rsp_cur   <= (rsp_bytes == 5) ? 8'h01 : 8'hFF;
      end else begin
        rsp_bits <= rsp_bits + 3'd1;
      end
    end
  end

  assign bus.miso = mode_resp ? rsp_cur[3'd7 - rsp_bits] : bus.mosi;

  logic sck_prev = 1'b0;
  logic ss_prev  = 1'b1;
  logic ss_high_seen, ss_low_seen, mosi_low_seen;
  int   sck_pulses, sck_high_cyc, last_fall_cyc, ss_rise_cyc, last_rx_cyc, acc_cyc;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.sck && !sck_prev) sck_pulses++;
    if (!bus.sck && sck_prev) last_fall_cyc = cyc;
    if (bus.sck) sck_high_cyc++;
    if (bus.ss && !ss_prev) ss_rise_cyc = cyc;
    if (bus.ss) ss_high_seen = 1'b1;
    else ss_low_seen = 1'b1;
    if (!bus.mosi) mosi_low_seen = 1'b1;
    sck_prev = bus.sck;
    ss_prev  = bus.ss;
    if (bus.rx_valid) begin
      last_rx_cyc = cyc;
      rx_cyc_q.push_back(cyc);
      check("rx_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("rx_data", int'(bus.rx_data), int'(exp_q.pop_front()));
    end
  endtask

  // Leaves tx_valid high so consecutive calls stream.
  task automatic send(input logic [7:0] b, input bit push, input logic [7:0] e);
    int n = 0;
    if (push) exp_q.push_back(e);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && n < 200) begin
      step();
      n++;
    end
    if (!bus.tx_ready) check("accept_timeout", int'(bus.tx_ready), 1);
    step();
    acc_cyc = cyc;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cmd[8];
    logic [7:0] rsp[8];
    int n;
    cmd = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF};
    rsp = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'hFF};

    bus.div      = 8'd0;
    bus.cs_en    = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;

    step();
    step();
    check("rst_sck", int'(bus.sck), 0);
    check("rst_mosi", int'(bus.mosi), 1);
    check("rst_ss", int'(bus.ss), 1);
    check("rst_tx_ready", int'(bus.tx_ready), 0);
    check("rst_rx_valid", int'(bus.rx_valid), 0);
    check("rst_rx_data", int'(bus.rx_data), 0);
    check("rst_busy", int'(bus.busy), 0);
    rst = 1'b0;
    step();
    check("tx_ready_after_rst", int'(bus.tx_ready), 1);

    // Reset in the middle of bit 4 of 0xC3 (mosi low there), div=3.
    bus.div    = 8'd3;
    bus.cs_en  = 1'b1;
    sck_pulses = 0;
    send(8'hC3, 1'b0, 8'h00);
    bus.tx_valid = 1'b0;
    n = 0;
    while (sck_pulses < 4 && n < 200) begin
      step();
      n++;
    end
    check("midbyte_busy_before", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    check("midrst_sck", int'(bus.sck), 0);
    check("midrst_ss", int'(bus.ss), 1);
    check("midrst_mosi", int'(bus.mosi), 1);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_rx_valid", int'(bus.rx_valid), 0);
    step();
    step();
    rst = 1'b0;
    check("midrst_tx_ready_low", int'(bus.tx_ready), 0);
    step();
    check("midrst_tx_ready_rise", int'(bus.tx_ready), 1);

    // Loopback 0xA5 at div=1.
    bus.div = 8'd1;
    step();
    sck_pulses   = 0;
    sck_high_cyc = 0;
    send(8'hA5, 1'b1, 8'hA5);
    bus.tx_valid = 1'b0;
    drain();
    check("a5_latency", last_rx_cyc - acc_cyc, 33);
    check("a5_sck_pulses", sck_pulses, 8);
    check("a5_sck_high_cycles", sck_high_cyc, 16);

    // Stream three bytes at div=0.
    bus.div      = 8'd0;
    ss_high_seen = 1'b0;
    sck_pulses   = 0;
    rx_cyc_q.delete();
    send(8'h12, 1'b1, 8'h12);
    send(8'h34, 1'b1, 8'h34);
    send(8'h56, 1'b1, 8'h56);
    bus.tx_valid = 1'b0;
    drain();
    check("stream_rx_count", rx_cyc_q.size(), 3);
    if (rx_cyc_q.size() >= 3) begin
      check("stream_gap_1", rx_cyc_q[1] - rx_cyc_q[0], 17);
      check("stream_gap_2", rx_cyc_q[2] - rx_cyc_q[1], 17);
    end
    check("stream_ss_low", int'(ss_high_seen), 0);
    check("stream_sck_pulses", sck_pulses, 24);

    // CMD0 against the responder, then polls.
    bus.div   = 8'd1;
    mode_resp = 1'b1;
    for (int i = 0; i < 8; i++) send(cmd[i], 1'b1, rsp[i]);
    bus.tx_valid = 1'b0;
    drain();
    mode_resp = 1'b0;

    // Drop cs_en during bit 3.
    sck_pulses  = 0;
    ss_rise_cyc = 0;
    send(8'h3C, 1'b1, 8'h3C);
    bus.tx_valid = 1'b0;
    n = 0;
    while (sck_pulses < 5 && n < 200) begin
      step();
      n++;
    end
    bus.cs_en = 1'b0;
    step();
    check("csdrop_ss_held", int'(bus.ss), 0);
    drain();
    step();
    step();
    check("csdrop_ss_rise", ss_rise_cyc - last_fall_cyc, 1);
    check("csdrop_ss_final", int'(bus.ss), 1);

    // Ten 0xFF with ss released (SD init clocks).
    ss_low_seen   = 1'b0;
    mosi_low_seen = 1'b0;
    sck_pulses    = 0;
    bus.div       = 8'd0;
    for (int i = 0; i < 10; i++) send(8'hFF, 1'b1, 8'hFF);
    bus.tx_valid = 1'b0;
    drain();
    check("init_sck_pulses", sck_pulses, 80);
    check("init_ss_high", int'(ss_low_seen), 0);
    check("init_mosi_high", int'(mosi_low_seen), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
